// File: rtl/fetch_unit.sv
// Fetch unit: program counter, instruction register and optional return stack.
// Optional return stack built only when FETCH_CALLSTACK_EN is defined.
module fetch_unit #(
    parameter logic [6:0] RESET_PC    = 7'd0,
    parameter int         STACK_DEPTH = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        Ena,
    input  logic        PC_EN,
    input  logic        PC_LOAD,
    input  logic        IR_EN,
    input  logic [11:0] MEM_DATA,
    output logic [6:0]  PC_ADDR,
    output logic [3:0]  OPCODE,
    output logic        I_Flag,
    output logic [6:0]  InstADDR,
    output logic        STK_OVF,
    output logic        STK_UNF
);

    generate
        if (STACK_DEPTH < 2 || STACK_DEPTH > 8) begin : g_bad_depth
            $error("fetch_unit: STACK_DEPTH must be 2..8");
        end
    endgenerate

    logic [6:0]  r_pc;
    logic [11:0] r_ir;
    logic [6:0]  w_pc_inc;
    logic [6:0]  w_pc_next;

    assign PC_ADDR  = r_pc;
    assign OPCODE   = r_ir[11:8];
    assign I_Flag   = r_ir[7];
    assign InstADDR = r_ir[6:0];
    assign w_pc_inc = r_pc + 7'd1;

`ifdef FETCH_CALLSTACK_EN
    localparam int SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = $clog2(STACK_DEPTH);
    localparam logic [3:0] OP_CALL = 4'hE;
    localparam logic [3:0] OP_RET  = 4'hF;

    logic [6:0]       r_stack [STACK_DEPTH];
    logic [SP_W-1:0]  r_sp;
    logic [SP_W-1:0]  w_sp_next;
    logic             r_ovf;
    logic             r_unf;
    logic             w_ovf_next;
    logic             w_unf_next;
    logic             w_push;
    logic             w_full;
    logic             w_empty;
    logic [IDX_W-1:0] w_push_idx;
    logic [IDX_W-1:0] w_top_idx;

    assign w_full     = (r_sp == SP_W'(STACK_DEPTH));
    assign w_empty    = (r_sp == '0);
    assign w_push_idx = IDX_W'(r_sp);
    assign w_top_idx  = IDX_W'(r_sp - SP_W'(1));
    assign STK_OVF    = r_ovf;
    assign STK_UNF    = r_unf;

    // Jump decode; the pre-edge IR selects CALL/RET even if IR reloads this cycle.
    always_comb begin
        w_pc_next  = r_pc;
        w_sp_next  = r_sp;
        w_ovf_next = r_ovf;
        w_unf_next = r_unf;
        w_push     = 1'b0;
        if (PC_EN) begin
            if (!PC_LOAD) begin
                w_pc_next = w_pc_inc;
            end else if (OPCODE == OP_CALL) begin
                w_pc_next = InstADDR;
                if (w_full) begin
                    w_ovf_next = 1'b1;
                end else begin
                    w_push    = 1'b1;
                    w_sp_next = r_sp + SP_W'(1);
                end
            end else if (OPCODE == OP_RET) begin
                if (w_empty) begin
                    w_unf_next = 1'b1;
                    w_pc_next  = w_pc_inc;
                end else begin
                    w_pc_next = r_stack[w_top_idx];
                    w_sp_next = r_sp - SP_W'(1);
                end
            end else begin
                w_pc_next = InstADDR;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_sp  <= '0;
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else if (Ena) begin
            r_sp  <= w_sp_next;
            r_ovf <= w_ovf_next;
            r_unf <= w_unf_next;
        end
    end

    // Contents need no reset: an empty pointer makes stale entries unreachable.
    always_ff @(posedge CLK) begin
        if (RST && Ena && w_push) begin
            r_stack[w_push_idx] <= w_pc_inc;
        end
    end
`else
    assign STK_OVF = 1'b0;
    assign STK_UNF = 1'b0;

    always_comb begin
        w_pc_next = r_pc;
        if (PC_EN) begin
            w_pc_next = PC_LOAD ? InstADDR : w_pc_inc;
        end
    end
`endif

    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_pc <= RESET_PC;
            r_ir <= 12'h000;
        end else if (Ena) begin
            r_pc <= w_pc_next;
            if (IR_EN) begin
                r_ir <= MEM_DATA;
            end
        end
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameters (name, default, meaning):
- RESET_PC, 7'd0, PC value loaded at reset.
- STACK_DEPTH, 4, number of return-stack entries (power of two, 2..8).

REQ-002 Ports (name, direction, width, meaning):
- CLK  in  1  single clock; all state changes on the rising edge.
- RST  in  1  synchronous active-low reset.
- Ena  in  1  global enable; low holds all state.
- PC_EN  in  1  PC update strobe from the controller.
- PC_LOAD  in  1  qualifies PC_EN as a jump (load) instead of an increment.
- IR_EN  in  1  instruction register load strobe.
- MEM_DATA  in  12  instruction word from program memory.
- PC_ADDR  out  7  current PC, drives the program memory address.
- OPCODE  out  4  IR[11:8].
- I_Flag  out  1  IR[7].
- InstADDR  out  7  IR[6:0].
- STK_OVF  out  1  sticky return-stack overflow flag.
- STK_UNF  out  1  sticky return-stack underflow flag.

Function
REQ-003 OPCODE, I_Flag and InstADDR SHALL be combinational slices of the IR register, with no added latency.

REQ-004 PC_ADDR SHALL be the PC register output directly.

REQ-005 With Ena=1 and IR_EN=1, IR SHALL load MEM_DATA at the clock edge; the new value is visible the next cycle.

REQ-006 With Ena=1, PC_EN=1 and PC_LOAD=0, PC SHALL become (PC+1) mod 128; 127 wraps to 0 with no flag.

REQ-007 With Ena=1, PC_EN=1 and PC_LOAD=1, PC SHALL become InstADDR, except as modified by REQ-011 and REQ-012.

REQ-008 PC_LOAD=1 with PC_EN=0 SHALL be ignored.

REQ-009 When IR_EN and PC_EN are asserted in the same cycle, both registers SHALL update, and the PC SHALL use the pre-edge IR contents.

REQ-010 With Ena=0, PC, IR, stack and flags SHALL hold regardless of the other strobes.

REQ-011 CALL (OPCODE=4'hE) with PC_EN and PC_LOAD both 1:
- Stack not full: push (PC+1) mod 128, then PC<=InstADDR.
- Stack full: no push, STK_OVF<=1, PC<=InstADDR.

REQ-012 RET (OPCODE=4'hF) with PC_EN and PC_LOAD both 1:
- Stack not empty: pop, then PC<=popped entry; InstADDR is ignored.
- Stack empty: STK_UNF<=1, PC<=(PC+1) mod 128.

REQ-013 At most one push or pop SHALL occur per cycle.

REQ-014 The stack SHALL be LIFO with a pointer ranging 0..STACK_DEPTH.
- Full when pointer=STACK_DEPTH; empty when pointer=0.
- Stack contents are not observable except via RET.

REQ-015 STK_OVF and STK_UNF SHALL be sticky; only reset clears them.

Reset
REQ-016 When RST=0 at a rising CLK edge, the block SHALL set PC=RESET_PC, IR=12'h000, stack pointer=0, STK_OVF=0 and STK_UNF=0.

REQ-017 Reset SHALL take priority over Ena and all strobes.

REQ-018 Outputs immediately after reset SHALL be: PC_ADDR=RESET_PC, OPCODE=0, I_Flag=0, InstADDR=0, flags 0.

REQ-019 A reset asserted mid-CALL/RET sequence SHALL discard all stack contents; no partial push or pop survives.

Configuration
REQ-020 Macro FETCH_CALLSTACK_EN:
- Defined: REQ-011 through REQ-015 apply.
- Undefined: no stack storage is built; CALL and RET behave as an ordinary load per REQ-007; STK_OVF and STK_UNF are tied to 0.

Verification
REQ-021 Reset, then 130 cycles of PC_EN=1, PC_LOAD=0 -> PC_ADDR steps 0,1,...,127,0,1; flags stay 0.

REQ-022 MEM_DATA=12'h3A5, IR_EN=1 -> next cycle OPCODE=3, I_Flag=1, InstADDR=7'h25; then PC_EN=PC_LOAD=1 -> PC_ADDR=7'h25.

REQ-023 Same-cycle IR_EN=1 (MEM_DATA=12'h011) and jump while IR=12'h050 -> PC_ADDR=7'h50 and InstADDR=7'h11.

REQ-024 (macro on, STACK_DEPTH=4) PC=10, CALL to 7'h40 -> PC_ADDR=7'h40; then RET -> PC_ADDR=11.

REQ-025 (macro on) 5 CALLs -> STK_OVF=1 after the fifth, and PC still jumps; then 5 RETs -> 4 returns, the fifth sets STK_UNF=1 and increments PC.

REQ-026 Ena=0 with all strobes high -> no state change; RST=0 with Ena=0 -> full reset to REQ-018 values.
